// File: rtl/rv_pkg.sv
// Shared register-file write types for the writeback path.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One register-file write request, used by both the pipeline and mul/div.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding mul/div results until they win the write port.
module wb_result_fifo
    import rv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  wb_req_t i_push_req,
    input  logic    i_pop,
    output wb_req_t o_head_c,
    output logic    o_full_c
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [REG_ADDR_W-1:0] rd_mem_q   [FIFO_DEPTH];
    logic [XLEN-1:0]       data_mem_q [FIFO_DEPTH];

    logic empty;
    logic push_ok;
    logic pop_ok;

    always_comb begin
        empty   = (count_q == '0);
        o_full_c = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok = i_push_req.valid && !o_full_c;
        pop_ok  = i_pop && !empty;

        o_head_c.valid = !empty;
        o_head_c.rd    = rd_mem_q[rd_ptr_q];
        o_head_c.data  = data_mem_q[rd_ptr_q];
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            rd_mem_q[wr_ptr_q]   <= i_push_req.rd;
            data_mem_q[wr_ptr_q] <= i_push_req.data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback stage and buffered mul/div results, and tracks pending mul/div rds.
module wb_port_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wb_valid,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]       i_wb_data,
    output logic                  o_wb_stall,
    input  logic                  i_md_valid,
    input  logic [REG_ADDR_W-1:0] i_md_rd,
    input  logic [XLEN-1:0]       i_md_data,
    output logic                  o_md_ready,
    input  logic                  i_md_issue,
    input  logic [REG_ADDR_W-1:0] i_md_issue_rd,
    output logic [XLEN-1:0]       o_rd_busy,
    output logic                  o_rf_we,
    output logic [REG_ADDR_W-1:0] o_rf_waddr,
    output logic [XLEN-1:0]       o_rf_wdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    wb_req_t wb_req;
    wb_req_t md_push_req;
    wb_req_t md_head;
    wb_req_t grant;
    logic    fifo_full;
    logic    wait_at_max;
    logic    md_win;

    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [XLEN-1:0]       busy_q, busy_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

    wb_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push_req (md_push_req),
        .i_pop      (md_win),
        .o_head_c   (md_head),
        .o_full_c   (fifo_full)
    );

    // Per-cycle grant: mul/div wins when full, starved, or the pipeline is idle.
    always_comb begin
        wb_req.valid      = i_wb_valid;
        wb_req.rd         = i_wb_rd;
        wb_req.data       = i_wb_data;
        md_push_req.valid = i_md_valid;
        md_push_req.rd    = i_md_rd;
        md_push_req.data  = i_md_data;

        wait_at_max = (wait_q >= WAIT_W'(MAX_WAIT));
        md_win      = md_head.valid && (fifo_full || wait_at_max || !i_wb_valid);
        grant       = md_win ? md_head : wb_req;

        o_md_ready = !fifo_full;
        o_wb_stall = md_win && i_wb_valid;
    end

    // Next-state for write port, starvation counter and scoreboard.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wait_d     = wait_q;
        busy_d     = busy_q;

        if (grant.valid) begin
            rf_we_d    = (grant.rd != REG_ZERO);
            rf_waddr_d = grant.rd;
            rf_wdata_d = grant.data;
        end

        if (!md_head.valid || md_win) begin
            wait_d = '0;
        end else if (!wait_at_max) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        // A same-cycle issue to the retiring rd must leave the bit set.
        if (md_win && (md_head.rd != REG_ZERO)) begin
            busy_d[md_head.rd] = 1'b0;
        end
        if (i_md_issue && (i_md_issue_rd != REG_ZERO)) begin
            busy_d[i_md_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_q     <= '0;
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign o_rd_busy  = busy_q;
    assign o_rf_we    = rf_we_q;
    assign o_rf_waddr = rf_waddr_q;
    assign o_rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed checks of wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic [31:0] rd_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks;
    int n_pass;

    // Reference model state
    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    int          m_wait;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    wb_port_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_wb_data     (wb_data),
        .o_wb_stall    (wb_stall),
        .i_md_valid    (md_valid),
        .i_md_rd       (md_rd),
        .i_md_data     (md_data),
        .o_md_ready    (md_ready),
        .i_md_issue    (md_issue),
        .i_md_issue_rd (md_issue_rd),
        .o_rd_busy     (rd_busy),
        .o_rf_we       (rf_we),
        .o_rf_waddr    (rf_waddr),
        .o_rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_rd.delete();
        q_data.delete();
        m_wait  = 0;
        m_busy  = '0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic drive_idle();
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        md_valid    = 1'b0;
        md_rd       = '0;
        md_data     = '0;
        md_issue    = 1'b0;
        md_issue_rd = '0;
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic wbv, input logic [4:0] wrd, input logic [31:0] wdat,
                        input logic mdv, input logic [4:0] mrd, input logic [31:0] mdat,
                        input logic iss, input logic [4:0] ird);
        bit full;
        bit empty;
        bit md_win;
        logic [4:0]  hrd;
        logic [31:0] hdata;
        @(negedge clk);
        wb_valid = wbv; wb_rd = wrd; wb_data = wdat;
        md_valid = mdv; md_rd = mrd; md_data = mdat;
        md_issue = iss; md_issue_rd = ird;
        #1;
        full   = (q_rd.size() == DEPTH);
        empty  = (q_rd.size() == 0);
        md_win = !empty && (full || m_wait >= MAX_WAIT || !wbv);

        check_eq("md_ready", 32'(md_ready), 32'(!full));
        check_eq("wb_stall", 32'(wb_stall), 32'(md_win && wbv));
        check_eq("rf_we", 32'(rf_we), 32'(m_we));
        if (m_we) begin
            check_eq("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            check_eq("rf_wdata", rf_wdata, m_wdata);
        end
        check_eq("rd_busy", rd_busy, m_busy);

        if (md_win) begin
            hrd   = q_rd.pop_front();
            hdata = q_data.pop_front();
            m_we    = (hrd != 5'd0);
            m_waddr = hrd;
            m_wdata = hdata;
            if (hrd != 5'd0) m_busy[hrd] = 1'b0;
            m_wait = 0;
        end else begin
            if (wbv) begin
                m_we    = (wrd != 5'd0);
                m_waddr = wrd;
                m_wdata = wdat;
            end else begin
                m_we = 1'b0;
            end
            m_wait = empty ? 0 : ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1);
        end
        if (mdv && !full) begin
            q_rd.push_back(mrd);
            q_data.push_back(mdat);
        end
        if (iss && ird != 5'd0) m_busy[ird] = 1'b1;
    endtask

    // Asynchronous reset in the middle of a cycle.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_eq("rst_rf_we", 32'(rf_we), 32'(0));
        check_eq("rst_busy", rd_busy, 32'(0));
        check_eq("rst_md_ready", 32'(md_ready), 32'(1));
        check_eq("rst_wb_stall", 32'(wb_stall), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rf_we", 32'(rf_we), 32'(0));
        check_eq("reset_waddr", 32'(rf_waddr), 32'(0));
        check_eq("reset_wdata", rf_wdata, 32'(0));
        check_eq("reset_busy", rd_busy, 32'(0));
        check_eq("reset_md_ready", 32'(md_ready), 32'(1));
        check_eq("reset_wb_stall", 32'(wb_stall), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pipeline writes, including rd=0
        step(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
        step(1, 5'd0, 32'h5555, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Idle pipeline: issue then result retires immediately
        step(0, 0, 0, 0, 0, 0, 1, 5'd7);
        step(0, 0, 0, 1, 5'd7, 32'hAA, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation limit with the pipeline always busy
        step(1, 5'd1, 32'h100, 1, 5'd3, 32'hC3, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 5'd1, 32'h101 + i, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // FIFO full: two pushes while pipeline busy
        step(1, 5'd2, 32'h200, 1, 5'd10, 32'hA0, 0, 0);
        step(1, 5'd2, 32'h201, 1, 5'd11, 32'hA1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 5'd2, 32'h202 + i, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard set/clear conflict on the same rd
        step(0, 0, 0, 0, 0, 0, 1, 5'd9);
        step(0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd9);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with a buffered entry and busy bits set
        step(0, 0, 0, 0, 0, 0, 1, 5'd12);
        step(1, 5'd4, 32'h44, 1, 5'd12, 32'hCC, 0, 0);
        mid_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                mid_reset();
            end else begin
                step(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom(),
                     ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 15)), $urandom(),
                     ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 15)));
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
